// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: types shared by the MIPS core pipeline stages.
// Register names, memop bundle, LSU state encoding, data defaults.
package mips_cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef logic [31:0] word_t;
  typedef logic [63:0] double_word_t;

  typedef enum logic [1:0] {
    LS_NONE,
    LS_LOAD,
    LS_STORE
  } ls_type_e;

  typedef enum logic [1:0] {
    LS_BYTE,
    LS_HALF,
    LS_WORD
  } ls_width_e;

  typedef struct packed {
    ls_type_e  ls_type;
    ls_width_e ls_width;
    logic      sign;
  } memop_struct;

  typedef enum logic [4:0] {
    R_ZERO, R_AT, R_V0, R_V1,
    R_A0, R_A1, R_A2, R_A3,
    R_T0, R_T1, R_T2, R_T3,
    R_T4, R_T5, R_T6, R_T7,
    R_S0, R_S1, R_S2, R_S3,
    R_S4, R_S5, R_S6, R_S7,
    R_T8, R_T9, R_K0, R_K1,
    R_GP, R_SP, R_FP, R_RA
  } reg_enum;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-enable, store lane placement and load extraction.
// Purely combinational; shared by request and response paths.
module lsu_lane_align
  import mips_cpu_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int NB     = DATA_W / 8,
  localparam int OFS    = $clog2(NB)
) (
  input  logic [OFS-1:0]    ofs,
  input  ls_width_e         ls_width,
  input  logic              sign,
  input  word_t             st_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output word_t             ld_data
);

  logic [OFS-1:0]    wofs;
  logic [DATA_W-1:0] sh;

  assign wofs = ofs & ~OFS'(3);
  assign sh   = rd_data >> {ofs, 3'b000};

  always_comb begin
    be      = '0;
    wdata   = '0;
    ld_data = '0;
    unique case (1'b1)
      (ls_width == LS_BYTE): begin
        be      = NB'(1) << ofs;
        wdata   = {NB{st_data[7:0]}};
        ld_data = {{24{sign & sh[7]}}, sh[7:0]};
      end
      (ls_width == LS_HALF): begin
        be      = NB'(3) << ofs;
        wdata   = {(NB/2){st_data[15:0]}};
        ld_data = {{16{sign & sh[15]}}, sh[15:0]};
      end
      default: begin
        be      = NB'(15) << wofs;
        wdata   = {(NB/4){st_data}};
        ld_data = sh[31:0];
      end
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu: MEM stage, req/gnt/rvalid data memory port.
// MEM_MISALIGN_TRAP_EN: misaligned accesses trap via out_excp.
module stage_mem_lsu
  import mips_cpu_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int NB     = DATA_W / 8,
  localparam int OFS    = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dm2rf,
  input  logic              in_hilowe,
  input  logic              in_rfwe,
  input  reg_enum           in_rfwa,
  input  double_word_t      in_mulres,
  input  word_t             in_alures,
  input  word_t             in_stdata,
  input  memop_struct       in_memop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dm2rf,
  output logic              out_hilowe,
  output logic              out_rfwe,
  output reg_enum           out_rfwa,
  output double_word_t      out_mulres,
  output word_t             out_alures,
  output word_t             out_ldata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              out_excp,
`endif
  output logic              dm_req,
  input  logic              dm_gnt,
  output logic              dm_we,
  output logic [NB-1:0]     dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata
);

  lsu_state_e        state, state_n;
  memop_struct       lat_op;
  logic [OFS-1:0]    lat_ofs;
  logic              in_fire, is_mem, go_mem;
  logic [OFS-1:0]    ofs_raw, ofs_al, ofs_sel;
  ls_width_e         w_sel;
  logic [NB-1:0]     be_w;
  logic [DATA_W-1:0] wdata_w;
  word_t             ld_w;
  logic [ADDR_W-1:0] addr_al;

  assign in_ready = (state == LSU_IDLE) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign is_mem   = in_memop.ls_type inside {LS_LOAD, LS_STORE};
  assign ofs_raw  = in_alures[OFS-1:0];
  assign addr_al  = ADDR_W'(in_alures) & ~ADDR_W'(NB - 1);

  // Offset bits below the access size are dropped (forced alignment).
  always_comb begin
    ofs_al = ofs_raw;
    unique case (1'b1)
      (in_memop.ls_width == LS_HALF): ofs_al[0] = 1'b0;
      (in_memop.ls_width == LS_WORD): ofs_al[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap;
  assign trap   = is_mem && (ofs_al != ofs_raw);
  assign go_mem = is_mem && !trap;
`else
  assign go_mem = is_mem;
`endif

  assign ofs_sel = (state == LSU_IDLE) ? ofs_al : lat_ofs;
  assign w_sel   = (state == LSU_IDLE) ? in_memop.ls_width
                                       : lat_op.ls_width;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .ofs      (ofs_sel),
    .ls_width (w_sel),
    .sign     (lat_op.sign),
    .st_data  (in_stdata),
    .rd_data  (dm_rdata),
    .be       (be_w),
    .wdata    (wdata_w),
    .ld_data  (ld_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LSU_IDLE: if (in_fire && go_mem) state_n = LSU_REQ;
      LSU_REQ: if (dm_gnt) begin
        state_n = (lat_op.ls_type == LS_LOAD) ? LSU_RESP
                                              : LSU_IDLE;
      end
      LSU_RESP: if (dm_rvalid) state_n = LSU_IDLE;
      default: state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_be      <= '0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      out_valid  <= 1'b0;
      out_dm2rf  <= 1'b0;
      out_hilowe <= 1'b0;
      out_rfwe   <= 1'b0;
      out_rfwa   <= R_ZERO;
      out_mulres <= '0;
      out_alures <= '0;
      out_ldata  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_excp   <= 1'b0;
`endif
      lat_op     <= '0;
      lat_ofs    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        LSU_IDLE: if (in_fire) begin
          out_dm2rf  <= in_dm2rf;
          out_hilowe <= in_hilowe;
          out_rfwe   <= in_rfwe;
          out_rfwa   <= in_rfwa;
          out_mulres <= in_mulres;
          out_alures <= in_alures;
          out_ldata  <= '0;
          lat_op     <= in_memop;
          lat_ofs    <= ofs_al;
          if (go_mem) begin
            dm_req   <= 1'b1;
            dm_we    <= (in_memop.ls_type == LS_STORE);
            dm_be    <= be_w;
            dm_addr  <= addr_al;
            dm_wdata <= wdata_w;
          end else begin
            out_valid <= 1'b1;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          out_excp <= trap;
          if (trap) begin
            out_rfwe  <= 1'b0;
            out_dm2rf <= 1'b0;
          end
`endif
        end
        LSU_REQ: if (dm_gnt) begin
          dm_req <= 1'b0;
          dm_we  <= 1'b0;
          if (lat_op.ls_type != LS_LOAD) out_valid <= 1'b1;
        end
        LSU_RESP: if (dm_rvalid) begin
          out_ldata <= ld_w;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stage_mem_lsu.md
# stage_mem_lsu

Parametrised memory stage between the EX/MEM and MEM/WB pipeline registers of the MIPS core. Drives a data memory with variable latency over a req/gnt/rvalid handshake. Places store data on byte lanes and generates byte enables from the address offset. Returns loads already shifted and sign/zero-extended. Back-pressure runs upstream via valid/ready, so a slow memory stalls the pipeline instead of corrupting it.

## Interface
Parameters:
- DATA_W, 32 — data-memory word width; 32 or 64; NB = DATA_W/8 byte lanes, OFS = log2(NB).
- ADDR_W, 32 — byte address width presented to memory.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  EX/MEM handshake; transfer when both are high
- in_dm2rf, in_hilowe, in_rfwe  in  1 each  control bits passed through to WB
- in_rfwa  in  reg_enum  destination register
- in_mulres  in  2*32  multiplier result, passed through
- in_alures  in  32  ALU result; memory address for load/store
- in_stdata  in  32  store source data
- in_memop  in  memop_struct  fields ls_type (NONE/LOAD/STORE), ls_width (BYTE/HALF/WORD), sign
- out_valid / out_ready  out / in  1 / 1  MEM/WB handshake
- out_dm2rf, out_hilowe, out_rfwe, out_rfwa, out_mulres, out_alures  out  as in_*  registered copies
- out_ldata  out  32  aligned, extended load result; 0 for non-loads
- out_excp  out  1  misaligned access; present only with MEM_MISALIGN_TRAP_EN
- dm_req  out  1  memory request
- dm_gnt  in  1  memory accepts the request this cycle
- dm_we  out  1  1 = store
- dm_be  out  NB  byte enables
- dm_addr  out  ADDR_W  byte address with the low OFS bits cleared
- dm_wdata  out  DATA_W  lane-placed store data
- dm_rvalid  in  1  read data valid
- dm_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, RESP.
  - IDLE: in_ready = !out_valid || out_ready.
  - On transfer of a non-memory op, load the output register; out_valid = 1 next cycle.
  - On transfer of a LOAD or STORE, latch the op and go to REQ.
  - REQ: dm_req = 1. A STORE with dm_gnt loads the output register and returns to IDLE. A LOAD with dm_gnt goes to RESP.
  - RESP: wait for dm_rvalid. Then capture the processed dm_rdata into out_ldata, set out_valid, return to IDLE.
- Lane offset is ofs = alures[OFS-1:0].
- dm_be:
  - BYTE: 1 << ofs.
  - HALF: 2'b11 << ofs.
  - WORD: 4'b1111 << (ofs & ~3).
  - When DATA_W = 64, ofs[2] selects the word half.
- dm_wdata: the byte/half/word is replicated across every lane of its size.
- Load data processing: shift dm_rdata right by 8*ofs, keep the low 8/16/32 bits, then sign-extend if memop.sign, else zero-extend.
- Misaligned access: HALF with ofs[0] ≠ 0, or WORD with ofs[1:0] ≠ 0.
- Output register is held while out_valid && !out_ready.
- dm_rvalid outside RESP and dm_gnt outside REQ are ignored.

## Timing
- Reset values:
  - state = IDLE.
  - dm_req, dm_we, out_valid, out_excp, out_rfwe, out_dm2rf, out_hilowe = 0.
  - dm_be, dm_addr, dm_wdata, out_ldata, out_alures, out_mulres, out_rfwa = 0.
  - in_ready = 1 once reset is released.
- Latency from EX/MEM transfer to out_valid:
  - non-memory op: 1 cycle.
  - store: 1 + cycles to grant (minimum 2 with same-cycle gnt).
  - load: minimum 3 cycles (rvalid one cycle after gnt).
- dm_req, dm_we, dm_be, dm_addr and dm_wdata are registered. They stay stable from the cycle dm_req rises until the cycle dm_gnt is sampled high, and drop the next cycle.
- The memory must not assert dm_rvalid in the grant cycle. The block never issues a second request before the RESP of a load completes.
- Back-to-back throughput:
  - non-memory ops: 1 per cycle while out_ready = 1.
  - memory ops: serialised, because in_ready = 0 in REQ and RESP.
- Asserting rst_n low mid-REQ or mid-RESP aborts the access immediately: dm_req = 0, any pending rvalid is dropped, out_valid = 0.

## Configuration
- With MEM_MISALIGN_TRAP_EN defined, a misaligned LOAD or STORE:
  - issues no dm_req;
  - completes like a non-memory op (1 cycle);
  - sets out_excp = 1 and forces out_rfwe = 0 and out_dm2rf = 0.
- Without the macro, the out_excp port is absent. Address bits below the access size are cleared (forced alignment) and the access proceeds normally.

## Structure
- mips_cpu_pkg gains:
  - the lsu_state_e enum;
  - constants for DATA_W defaults;
  - memop_struct, reg_enum and word_t/double_word_t, shared unchanged.
- One sub-module, lsu_lane_align: purely combinational.
  - Inputs: ofs, ls_width, sign, store data, read data.
  - Outputs: dm_be, lane-placed store data, extended load data.

## Test plan
- SW of 0xDEADBEEF at 0x100 with gnt in the same cycle → dm_be = 4'b1111, dm_wdata = 0xDEADBEEF, out_valid 2 cycles after transfer.
- LB with sign = 1 at 0x103, dm_rdata = 0x80FF_FF00 → out_ldata = 0xFFFF_FF80. The same access with sign = 0 → out_ldata = 0x0000_0080.
- SH of 0x1234 at 0x102 → dm_be = 4'b1100, dm_wdata = 0x1234_1234. Grant withheld 3 cycles → request fields stable throughout, in_ready = 0.
- LW with out_ready = 0 for 4 cycles after completion → out_ldata held; next op accepted only after the drain cycle.
- LH at 0x101 → with MEM_MISALIGN_TRAP_EN: no dm_req, out_excp = 1, out_rfwe = 0. Without the macro: dm_addr = 0x100, dm_be = 4'b0011.
- rst_n asserted while in RESP, then a stray dm_rvalid → all outputs at reset values, no out_valid.
